// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS boot path.
// Holds the loader FSM state encoding and the stream framing constant.
package mips_pkg;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        DONE
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler.
// The first byte shifted in ends up in bits [7:0] after a full word.
module byte_packer
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift,
    input  logic              clr,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word_out,
    output logic              word_full
);

    logic [7:0] lane_reg [BYTES_PER_WORD];
    logic [1:0] byte_cnt_reg;

    // Each lane takes its upper neighbour; the top lane takes the new byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                lane_reg[i] <= 8'h00;
            end
            byte_cnt_reg <= 2'd0;
        end else if (clr) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                lane_reg[i] <= 8'h00;
            end
            byte_cnt_reg <= 2'd0;
        end else if (shift) begin
            for (int i = 0; i < BYTES_PER_WORD - 1; i++) begin
                lane_reg[i] <= lane_reg[i+1];
            end
            lane_reg[BYTES_PER_WORD-1] <= byte_in;
            byte_cnt_reg               <= byte_cnt_reg + 2'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            assign word_out[gi*8 +: 8] = lane_reg[gi];
        end
    endgenerate

    assign word_full = shift && (byte_cnt_reg == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a length-prefixed byte image, writes it into
// instruction memory and holds the MIPS core in reset until it is loaded.
module imem_boot_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              err
);

    localparam logic [LEN_W-1:0] MEM_DEPTH = LEN_W'(1 << ADDR_W);

    loader_state_t     state_reg, state_next;
    logic [LEN_W-1:0]  len_reg, len_next;
    logic [LEN_W-1:0]  word_cnt_reg, word_cnt_next;
    logic              err_reg, err_next;
    logic              cpu_reset_reg;
    logic              done_reg;

    logic              accept;
    logic              pack_shift;
    logic              pack_clr;
    logic [DATA_W-1:0] word_out;
    logic              word_full;
    logic [LEN_W-1:0]  len_full;

    assign in_ready   = (state_reg == LEN_LO) || (state_reg == LEN_HI) || (state_reg == DATA);
    assign accept     = in_valid && in_ready;
    assign pack_shift = accept && (state_reg == DATA);
    assign len_full   = LEN_W'({in_data, len_reg[7:0]});

    byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .shift     (pack_shift),
        .clr       (pack_clr),
        .byte_in   (in_data),
        .word_out  (word_out),
        .word_full (word_full)
    );

    always_comb begin
        state_next    = state_reg;
        len_next      = len_reg;
        word_cnt_next = word_cnt_reg;
        err_next      = err_reg;
        pack_clr      = 1'b0;
        case (state_reg)
            LEN_LO: begin
                if (accept) begin
                    len_next[7:0] = in_data;
                    state_next    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_next = len_full;
                    if (len_full == '0) begin
                        state_next = DONE;
                    end else begin
                        // Oversized images are still consumed so the stream stays framed.
                        if (len_full > MEM_DEPTH) begin
                            err_next = 1'b1;
                        end
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (word_full) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (word_cnt_reg == len_reg - LEN_W'(1)) begin
                    state_next = DONE;
                end else begin
                    word_cnt_next = word_cnt_reg + LEN_W'(1);
                    state_next    = DATA;
                end
            end
            DONE: begin
                if (start) begin
                    state_next    = LEN_LO;
                    err_next      = 1'b0;
                    word_cnt_next = '0;
                    pack_clr      = 1'b1;
                end
            end
            default: state_next = LEN_LO;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= LEN_LO;
            len_reg      <= '0;
            word_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            len_reg      <= len_next;
            word_cnt_reg <= word_cnt_next;
            err_reg      <= err_next;
        end
    end

    // Core release lags DONE by one cycle so the final write settles first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_reset_reg <= 1'b1;
            done_reg      <= 1'b0;
        end else begin
            cpu_reset_reg <= (state_reg != DONE);
            done_reg      <= (state_reg == DONE);
        end
    end

    assign imem_we    = (state_reg == WRITE) && (word_cnt_reg < MEM_DEPTH);
    assign imem_addr  = word_cnt_reg[ADDR_W-1:0];
    assign imem_wdata = word_out;
    assign cpu_reset  = cpu_reset_reg;
    assign done       = done_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader with an image-level write model
// and a shadow instruction memory filled from observed writes.
`timescale 1ns/1ps
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        start;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        err;

    imem_boot_loader dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .start      (start),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] shadow [64];
    int          checks = 0;
    int          errors = 0;
    int          acc_cnt = 0;
    bit          expect_busy = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Model: the image header gives the word count; only the first 64 words land.
    task automatic expect_image(input logic [7:0] s[$]);
        int len;
        len = int'({s[1], s[0]});
        for (int w = 0; w < len && w < 64; w++) begin
            exp_q.push_back('{addr: 6'(w),
                              data: {s[2+4*w+3], s[2+4*w+2], s[2+4*w+1], s[2+4*w]}});
        end
    endtask

    always @(posedge clk) begin
        if (reset && in_valid && in_ready) acc_cnt++;
    end

    always @(negedge clk) begin : compare
        wr_t e;
        if (reset) begin
            if (imem_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual addr=%0d data=%h required=no write",
                             imem_addr, imem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(imem_addr), 32'(e.addr));
                    check("wr_data", imem_wdata, e.data);
                    $display("write addr=%0d data=%h", imem_addr, imem_wdata);
                end
                shadow[imem_addr] = imem_wdata;
            end
            if (expect_busy) begin
                check("busy_cpu_reset", 32'(cpu_reset), 32'd1);
                check("busy_done", 32'(done), 32'd0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 0;
        @(negedge clk);
        start    = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 16 && !ok; i++) begin
            if (i > 0) @(negedge clk);
            ok = in_ready;
            @(posedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=not accepted required=accepted byte %h", b);
        end
    endtask

    task automatic stream(input logic [7:0] s[$], input bit toggle, input bit poke_start);
        expect_busy = 1;
        foreach (s[i]) begin
            send_byte(s[i]);
            if (toggle && i != s.size() - 1) begin
                @(negedge clk);
                in_valid = 1'b0;
                if (poke_start && i == 3) start = 1'b1;
            end
        end
        expect_busy = 0;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 50; i++) begin
            if (done) break;
            @(negedge clk);
        end
        check("done_wait", 32'(done), 32'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_ready", 32'(in_ready), 32'd1);
        check("start_err_clr", 32'(err), 32'd0);
        @(negedge clk);
        check("start_cpu_reset", 32'(cpu_reset), 32'd1);
        check("start_done", 32'(done), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s[$];
        int base;

        reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b1;

        // 1: two-word image and release latency
        s = '{8'h02, 8'h00, 8'h20, 8'h00, 8'h08, 8'h00, 8'h04, 8'h00, 8'h09, 8'h00};
        expect_image(s);
        stream(s, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("t1_we_last", 32'(imem_we), 32'd1);
        @(negedge clk);
        check("t1_cpu_reset_t1", 32'(cpu_reset), 32'd1);
        check("t1_we_off", 32'(imem_we), 32'd0);
        @(negedge clk);
        check("t1_cpu_reset_t2", 32'(cpu_reset), 32'd0);
        check("t1_done", 32'(done), 32'd1);
        check("t1_err", 32'(err), 32'd0);
        check("t1_mem0", shadow[0], 32'h00080020);
        check("t1_mem1", shadow[1], 32'h00090004);
        check("t1_pending", 32'(exp_q.size()), 32'd0);

        // 2: empty image
        pulse_start();
        s = '{8'h00, 8'h00};
        stream(s, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("t2_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("t2_cpu_reset", 32'(cpu_reset), 32'd0);
        check("t2_done", 32'(done), 32'd1);

        // 3: gapped stream with an ignored start mid-load
        pulse_start();
        base = acc_cnt;
        s = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
        expect_image(s);
        stream(s, 1, 1);
        idle();
        wait_done();
        check("t3_accepted", 32'(acc_cnt - base), 32'd6);
        check("t3_mem0", shadow[0], 32'h11223344);
        check("t3_pending", 32'(exp_q.size()), 32'd0);

        // 4: 65-word header overflows the 64-word memory
        pulse_start();
        s = '{8'h41, 8'h00};
        stream(s, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("t4_err_hdr", 32'(err), 32'd1);
        for (int k = 0; k < 260; k++) s.push_back(8'(k));
        expect_image(s);
        s = s[2:$];
        stream(s, 0, 0);
        idle();
        wait_done();
        check("t4_err_end", 32'(err), 32'd1);
        check("t4_mem0", shadow[0], 32'h03020100);
        check("t4_mem63", shadow[63], 32'hFFFEFDFC);
        check("t4_pending", 32'(exp_q.size()), 32'd0);

        // 6: re-arm clears err, new single-word image
        pulse_start();
        s = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        expect_image(s);
        stream(s, 0, 0);
        idle();
        wait_done();
        check("t6_mem0", shadow[0], 32'h12345678);
        check("t6_err", 32'(err), 32'd0);

        // 5: reset mid-load, then a full reload
        pulse_start();
        s = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD};
        stream(s, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("t5_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("t5_rst_in_ready", 32'(in_ready), 32'd1);
        check("t5_rst_we", 32'(imem_we), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        s = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        expect_image(s);
        stream(s, 0, 0);
        idle();
        wait_done();
        check("t5_mem0", shadow[0], 32'hDEADBEEF);
        check("t5_cpu_reset", 32'(cpu_reset), 32'd0);

        @(negedge clk);
        check("final_pending", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
